// File: rtl/roll_mem_writer_if.sv
// Request/write bus between a roll-table producer and its controller.
// The master issues fill, refill and seed requests; the slave drives the RAM write port and fill status.
interface roll_mem_writer_if;
    logic        start;
    logic        refill_req;
    logic [4:0]  refill_addr;
    logic        seed_load;
    logic [15:0] seed;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        busy;
    logic        done;
    logic [5:0]  valid_count;

    modport master (
        output start, refill_req, refill_addr, seed_load, seed,
        input  wr_en, wr_addr, wr_data, busy, done, valid_count
    );

    modport slave (
        input  start, refill_req, refill_addr, seed_load, seed,
        output wr_en, wr_addr, wr_data, busy, done, valid_count
    );
endinterface

// File: rtl/roll_mem_writer.sv
// Fills the d20 roll RAM with 5-bit values taken from a 16-bit Galois LFSR,
// supports single-entry refills and counts fill-written values in 1..20.
module roll_mem_writer #(
    parameter int          NUM_GROUP = 32,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    roll_mem_writer_if.slave  bus
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_FILL   = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam logic [5:0]  FILL_END  = 6'(NUM_GROUP);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

    function automatic logic in_d20_range(input logic [4:0] val);
        return (val >= 5'd1) && (val <= 5'd20);
    endfunction

    logic [1:0]  state_r;
    logic [15:0] lfsr_r;
    logic [5:0]  ptr_r;
    logic        wr_en_r;
    logic [4:0]  wr_addr_r;
    logic [4:0]  wr_data_r;
    logic        busy_r;
    logic        done_r;
    logic [5:0]  valid_count_r;

    // Control FSM, LFSR and registered write port; every write consumes exactly one LFSR step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            lfsr_r        <= SEED;
            ptr_r         <= 6'd0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= 5'd0;
            wr_data_r     <= 5'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            valid_count_r <= 6'd0;
        end else begin
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        // Entry 0 is written straight away so the fill spans exactly NUM_GROUP cycles.
                        state_r       <= ST_FILL;
                        busy_r        <= 1'b1;
                        wr_en_r       <= 1'b1;
                        wr_addr_r     <= 5'd0;
                        wr_data_r     <= lfsr_r[4:0];
                        lfsr_r        <= lfsr_step(lfsr_r);
                        ptr_r         <= 6'd1;
                        valid_count_r <= in_d20_range(lfsr_r[4:0]) ? 6'd1 : 6'd0;
                    end else if (bus.refill_req) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= bus.refill_addr;
                        wr_data_r <= lfsr_r[4:0];
                        lfsr_r    <= lfsr_step(lfsr_r);
                    end else if (bus.seed_load) begin
                        lfsr_r <= (bus.seed == 16'h0000) ? SEED : bus.seed;
                    end else begin
                        lfsr_r <= lfsr_r;
                    end
                end
                ST_FILL: begin
                    if (ptr_r == FILL_END) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        wr_en_r       <= 1'b1;
                        wr_addr_r     <= ptr_r[4:0];
                        wr_data_r     <= lfsr_r[4:0];
                        lfsr_r        <= lfsr_step(lfsr_r);
                        ptr_r         <= ptr_r + 6'd1;
                        valid_count_r <= valid_count_r + (in_d20_range(lfsr_r[4:0]) ? 6'd1 : 6'd0);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en       = wr_en_r;
    assign bus.wr_addr     = wr_addr_r;
    assign bus.wr_data     = wr_data_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.valid_count = valid_count_r;

endmodule

// File: doc/roll_mem_writer.md
# roll_mem_writer

Producer side of the d20 roll memory. The block generates 5-bit pseudo-random values with a 16-bit Galois LFSR and writes them into the roll RAM that the roll evaluator reads. It supports a full-table fill and single-entry refill on request. It also reports how many written entries fall in the valid d20 range 1..20.

## Interface

Parameters:
- NUM_GROUP, 32, number of RAM entries written per fill; address width is 5 bits, so NUM_GROUP ≤ 32
- SEED, 16'hACE1, LFSR value after reset; also replaces any zero seed

Ports:
- clk  input  1  single clock; all logic on posedge clk
- reset  input  1  synchronous, active-low reset; sampled on posedge clk
- start  input  1  one-cycle request to fill entries 0..NUM_GROUP-1
- refill_req  input  1  one-cycle request to rewrite one entry
- refill_addr  input  5  entry index for refill_req
- seed_load  input  1  load seed into the LFSR
- seed  input  16  new LFSR value
- wr_en  output  1  RAM write strobe
- wr_addr  output  5  RAM write address
- wr_data  output  5  RAM write data
- busy  output  1  high while a fill is in progress
- done  output  1  one-cycle pulse after the last fill write
- valid_count  output  6  count of fill-written values in 1..20

## Operation

- States: IDLE, FILL, DONE.
- LFSR is 16-bit Galois, right-shifting, with polynomial mask 16'hB400.
  - Step: if lfsr[0] is 1, next = (lfsr>>1)^16'hB400; otherwise next = lfsr>>1.
  - Every write uses wr_data = lfsr[4:0] of the current state, then the LFSR steps once. There is exactly one step per write and no step without a write.
- IDLE:
  - start=1: go to FILL, write pointer := 0, valid_count := 0.
  - else refill_req=1: next cycle issue one write, wr_addr=refill_addr, then stay in IDLE.
  - else seed_load=1: lfsr := (seed==0) ? SEED : seed.
  - Priority: start > refill_req > seed_load. Lower-priority requests in the same cycle are dropped.
- FILL:
  - One write per cycle at addresses 0,1,…,NUM_GROUP-1.
  - valid_count increments when 1 ≤ wr_data ≤ 20.
  - After address NUM_GROUP-1, go to DONE.
  - start, refill_req and seed_load are ignored.
- DONE: done=1 for one cycle, then go to IDLE. Requests in this cycle are ignored.
- refill writes do not change valid_count.
- valid_count holds its value until the next start.
- refill_addr ≥ NUM_GROUP: the write is issued anyway, because the reader indexes modulo the RAM size. This is not an error.

## Timing

- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, valid_count=0, lfsr=SEED, state=IDLE.
- Fill latency (start sampled high at edge N):
  - wr_en=1 and busy=1 during cycles N+1..N+NUM_GROUP, with wr_addr = 0..NUM_GROUP-1.
  - done=1 during cycle N+NUM_GROUP+1, with busy=0.
  - The next start is accepted from cycle N+NUM_GROUP+2.
- Refill latency: refill_req sampled at edge N → wr_en=1 for exactly cycle N+1. Back-to-back refill requests give one write per cycle.
- When wr_en=0, wr_addr and wr_data hold their last value.
- valid_count is final in the done cycle.
- Reset mid-fill (reset=0 at any edge): all outputs, state and LFSR return to reset values at that edge. There is no done pulse, and the partial table is left as written.
- Seed load takes effect at the edge where it is sampled. The next write uses the new lfsr[4:0].

## Test plan

- Reset then start, default SEED → the first three writes are addr 0/1/2 with data 1, 16, 24. busy is high for 32 cycles, done pulses once at N+33, and valid_count equals the reference-model count.
- seed_load with seed=16'h0000, then start → the write sequence is identical to the default-SEED run.
- refill_req with refill_addr=7 while IDLE → exactly one write at addr 7, with data equal to the current lfsr[4:0]. valid_count is unchanged and busy stays 0.
- start, refill_req and seed_load all high in the same IDLE cycle → a normal fill starts. The refill and seed are dropped, and the first data is the pre-existing lfsr[4:0].
- start and refill_req pulsed during FILL → ignored. Exactly 32 writes occur and a single done pulse.
- reset=0 at fill write 10 → all outputs are 0 on the next cycle and there is no done pulse. A following start reproduces the default-SEED sequence from addr 0.
